// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encodings, the iteration-counter width helper and the default operand width.
package div_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_TEST   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider_ctrl.sv
// Controller FSM for the restoring divider: sequences INIT, SHIFT/TEST pairs
// and FINISH, and emits the datapath enables plus the busy/done handshake.
module seq_divider_ctrl
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic i_last,
  input  logic r_ge_d,
  input  logic d_zero,
  output logic load,
  output logic shift,
  output logic sub,
  output logic dec,
  output logic publish,
  output logic busy,
  output logic done
);

  state_t state;
  state_t state_next;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; unknown encodings fall back to IDLE
  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_INIT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_INIT: begin
        if (d_zero) begin
          state_next = ST_FINISH;
        end else begin
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: state_next = ST_TEST;
      ST_TEST: begin
        if (i_last) begin
          state_next = ST_FINISH;
        end else begin
          state_next = ST_SHIFT;
        end
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output decode; publish fires on the edge that enters FINISH so results
  // are already visible while done is high
  always_comb begin
    load    = 1'b0;
    shift   = 1'b0;
    sub     = 1'b0;
    dec     = 1'b0;
    publish = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_INIT: begin
        busy    = 1'b1;
        load    = 1'b1;
        publish = d_zero;
      end
      ST_SHIFT: begin
        busy  = 1'b1;
        shift = 1'b1;
      end
      ST_TEST: begin
        busy    = 1'b1;
        dec     = 1'b1;
        sub     = r_ge_d;
        publish = i_last;
      end
      ST_FINISH: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider datapath (shift-subtract) with start/busy/done
// handshake. Define SIGNED_DIV_EN for two's-complement operands.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    i;
  logic             load, shift, sub, dec, publish;
  logic             i_last, r_ge_d, d_zero;
  logic [WIDTH:0]   r_diff;
  logic [WIDTH-1:0] q_fin, r_fin, quo_next, rem_next, dvd_mag, dvs_mag;
`ifdef SIGNED_DIV_EN
  logic             sign_q, sign_r;
`endif

  assign i_last = (i == CW'(1));
  assign r_ge_d = (r >= {1'b0, d});
  assign r_diff = r - {1'b0, d};
  assign d_zero = (divisor_in == '0);

  // Operand conditioning and final result formation (includes the last TEST step)
  always_comb begin
    q_fin = {q[WIDTH-1:1], r_ge_d};
    if (r_ge_d) begin
      r_fin = r_diff[WIDTH-1:0];
    end else begin
      r_fin = r[WIDTH-1:0];
    end
`ifdef SIGNED_DIV_EN
    dvd_mag  = dividend_in[WIDTH-1] ? (~dividend_in + WIDTH'(1)) : dividend_in;
    dvs_mag  = divisor_in[WIDTH-1]  ? (~divisor_in + WIDTH'(1))  : divisor_in;
    quo_next = sign_q ? (~q_fin + WIDTH'(1)) : q_fin;
    rem_next = sign_r ? (~r_fin + WIDTH'(1)) : r_fin;
`else
    dvd_mag  = dividend_in;
    dvs_mag  = divisor_in;
    quo_next = q_fin;
    rem_next = r_fin;
`endif
  end

  // Working registers: partial remainder, quotient/dividend shifter, divisor, count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
      q <= '0;
      d <= '0;
      i <= '0;
    end else if (load) begin
      r <= '0;
      q <= dvd_mag;
      d <= dvs_mag;
      i <= CW'(WIDTH);
    end else if (shift) begin
      {r, q} <= {r[WIDTH-1:0], q, 1'b0};
    end else if (dec) begin
      if (sub) begin
        r <= r_diff;
        q <= {q[WIDTH-1:1], 1'b1};
      end else begin
        r <= r;
      end
      i <= i - CW'(1);
    end else begin
      r <= r;
    end
  end

`ifdef SIGNED_DIV_EN
  // Result sign bookkeeping captured alongside the operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (load) begin
      sign_q <= dividend_in[WIDTH-1] ^ divisor_in[WIDTH-1];
      sign_r <= dividend_in[WIDTH-1];
    end else begin
      sign_q <= sign_q;
      sign_r <= sign_r;
    end
  end
`endif

  // Published results; publish together with load means a zero divisor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (publish && load) begin
      quotient    <= '1;
      remainder   <= dividend_in;
      div_by_zero <= 1'b1;
    end else if (publish) begin
      quotient    <= quo_next;
      remainder   <= rem_next;
    end else if (load) begin
      div_by_zero <= 1'b0;
    end else begin
      div_by_zero <= div_by_zero;
    end
  end

  seq_divider_ctrl u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .i_last  (i_last),
    .r_ge_d  (r_ge_d),
    .d_zero  (d_zero),
    .load    (load),
    .shift   (shift),
    .sub     (sub),
    .dec     (dec),
    .publish (publish),
    .busy    (busy),
    .done    (done)
  );

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider at WIDTH=4.
module tb_seq_divider;

  localparam int W = 4;

`ifdef SIGNED_DIV_EN
  localparam logic [W-1:0] Q13_3 = 4'hF, R13_3 = 4'h0;
  localparam logic [W-1:0] Q9_2  = 4'hD, R9_2  = 4'hF;
  localparam logic [W-1:0] Q10_3 = 4'hE, R10_3 = 4'h0;
`else
  localparam logic [W-1:0] Q13_3 = 4'h4, R13_3 = 4'h1;
  localparam logic [W-1:0] Q9_2  = 4'h4, R9_2  = 4'h1;
  localparam logic [W-1:0] Q10_3 = 4'h3, R10_3 = 4'h1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend_in = '0;
  logic [W-1:0] divisor_in = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;
  int n, bc, pulses;
  logic [W-1:0] q_seen, r_seen;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend_in (dividend_in),
    .divisor_in  (divisor_in),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns edges to done and busy cycles
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int edges, output int busy_cycles);
    dividend_in = a;
    divisor_in  = b;
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
    edges       = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) busy_cycles++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  initial begin
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dbz", div_by_zero, 1'b0);
    check("rst_q", quotient, 4'h0);
    check("rst_r", remainder, 4'h0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // 13 / 3
    run_div(4'd13, 4'd3, n, bc);
    check("13_3_latency", n, 9);
    check("13_3_busy_cycles", bc, 9);
    check("13_3_done", done, 1'b1);
    check("13_3_busy_in_finish", busy, 1'b0);
    check("13_3_q", quotient, Q13_3);
    check("13_3_r", remainder, R13_3);
    check("13_3_dbz", div_by_zero, 1'b0);
    @(posedge clk); #1;
    check("13_3_done_pulse", done, 1'b0);
    check("13_3_idle_busy", busy, 1'b0);
    check("13_3_q_hold", quotient, Q13_3);

    // 7 / 0 then 9 / 2 clears the flag
    run_div(4'd7, 4'd0, n, bc);
    check("7_0_latency", n, 1);
    check("7_0_q", quotient, 4'hF);
    check("7_0_r", remainder, 4'd7);
    check("7_0_dbz", div_by_zero, 1'b1);
    @(posedge clk); #1;
    check("7_0_dbz_hold", div_by_zero, 1'b1);
    run_div(4'd9, 4'd2, n, bc);
    check("9_2_latency", n, 9);
    check("9_2_q", quotient, Q9_2);
    check("9_2_r", remainder, R9_2);
    check("9_2_dbz", div_by_zero, 1'b0);
    @(posedge clk); #1;

    // Boundary operands
    run_div(4'd15, 4'd1, n, bc);
    check("15_1_q", quotient, 4'hF);
    check("15_1_r", remainder, 4'h0);
    @(posedge clk); #1;
    run_div(4'd2, 4'd5, n, bc);
    check("2_5_q", quotient, 4'h0);
    check("2_5_r", remainder, 4'h2);
    @(posedge clk); #1;
    run_div(4'd0, 4'd7, n, bc);
    check("0_7_q", quotient, 4'h0);
    check("0_7_r", remainder, 4'h0);
    @(posedge clk); #1;

    // Start pulsed with new operands while the 13/3 is in TEST
    dividend_in = 4'd13; divisor_in = 4'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dividend_in = 4'd6; divisor_in = 4'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    pulses = 0; q_seen = '0; r_seen = '0;
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) begin
        pulses++;
        q_seen = quotient;
        r_seen = remainder;
      end
      @(posedge clk); #1;
    end
    check("busy_start_pulses", pulses, 1);
    check("busy_start_q", q_seen, Q13_3);
    check("busy_start_r", r_seen, R13_3);
    check("busy_start_idle", busy, 1'b0);

    // Asynchronous reset mid-operation
    dividend_in = 4'd13; divisor_in = 4'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_q", quotient, 4'h0);
    check("midrst_r", remainder, 4'h0);
    check("midrst_dbz", div_by_zero, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_div(4'd10, 4'd3, n, bc);
    check("10_3_latency", n, 9);
    check("10_3_q", quotient, Q10_3);
    check("10_3_r", remainder, R10_3);
    @(posedge clk); #1;

`ifdef SIGNED_DIV_EN
    run_div(4'h9, 4'h2, n, bc);
    check("s_m7_2_q", quotient, 4'hD);
    check("s_m7_2_r", remainder, 4'hF);
    @(posedge clk); #1;
    run_div(4'h7, 4'hE, n, bc);
    check("s_7_m2_q", quotient, 4'hD);
    check("s_7_m2_r", remainder, 4'h1);
    @(posedge clk); #1;
    run_div(4'h8, 4'hF, n, bc);
    check("s_min_m1_q", quotient, 4'h8);
    check("s_min_m1_r", remainder, 4'h0);
    check("s_min_m1_dbz", div_by_zero, 1'b0);
    @(posedge clk); #1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
